// File: rtl/timer_bank_if.sv
// Run-request, load-register write and expiry/busy signals of the three-channel timer bank.
// The bank is the slave; whoever drives starts and configuration writes is the master.
interface timer_bank_if;
    logic        t0_start_in;
    logic        t1_start_in;
    logic        t2_start_in;
    logic        cfg_we_in;
    logic [1:0]  cfg_sel_in;
    logic [15:0] cfg_data_in;
    logic        t0_int_out;
    logic        t1_int_out;
    logic        t2_int_out;
    logic [2:0]  busy_out;

    modport master (
        output t0_start_in, t1_start_in, t2_start_in,
        output cfg_we_in, cfg_sel_in, cfg_data_in,
        input  t0_int_out, t1_int_out, t2_int_out,
        input  busy_out
    );

    modport slave (
        input  t0_start_in, t1_start_in, t2_start_in,
        input  cfg_we_in, cfg_sel_in, cfg_data_in,
        output t0_int_out, t1_int_out, t2_int_out,
        output busy_out
    );
endinterface

// File: rtl/timer_bank.sv
// Three independent prescaled down-counting timers.
// Each channel emits a one-cycle registered pulse (load+1)*PRESCALE cycles after its start is seen.
module timer_bank #(
    parameter int unsigned PRESCALE = 50000,
    parameter logic [15:0] T0_LOAD  = 16'd10,
    parameter logic [15:0] T1_LOAD  = 16'd10,
    parameter logic [15:0] T2_LOAD  = 16'd100
) (
    input  logic        clock_in,
    input  logic        reset_in,
    timer_bank_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [2:0] start_vec;
    logic [2:0] int_vec;
    logic [2:0] busy_vec;

    assign start_vec      = {bus.t2_start_in, bus.t1_start_in, bus.t0_start_in};
    assign bus.t0_int_out = int_vec[0];
    assign bus.t1_int_out = int_vec[1];
    assign bus.t2_int_out = int_vec[2];
    assign bus.busy_out   = busy_vec;

    for (genvar g = 0; g < 3; g++) begin : g_chan
        localparam logic [15:0] LOAD_INIT = (g == 0) ? T0_LOAD : ((g == 1) ? T1_LOAD : T2_LOAD);

        logic [15:0] load_q;
        logic [15:0] count_q;
        logic [15:0] count_next;
        logic [15:0] pre_q;
        logic [15:0] pre_next;
        state_t      state_q;
        state_t      state_next;
        logic        int_q;
        logic        int_next;
        logic        tick;

        assign tick = (pre_q == PRE_LAST);

        always_ff @(posedge clock_in) begin
            if (reset_in) begin
                load_q <= LOAD_INIT;
            end else if (bus.cfg_we_in && (bus.cfg_sel_in == 2'(g))) begin
                load_q <= bus.cfg_data_in;
            end
        end

        always_ff @(posedge clock_in) begin
            if (reset_in) begin
                state_q <= IDLE;
                count_q <= 16'd0;
                pre_q   <= 16'd0;
                int_q   <= 1'b0;
            end else begin
                state_q <= state_next;
                count_q <= count_next;
                pre_q   <= pre_next;
                int_q   <= int_next;
            end
        end

        // Dropping start always wins, so an abort on the expiry tick yields no pulse.
        always_comb begin
            state_next = state_q;
            count_next = count_q;
            pre_next   = pre_q;
            int_next   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_vec[g]) begin
                        count_next = load_q;
                        pre_next   = 16'd0;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!start_vec[g]) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        pre_next = 16'd0;
                        if (count_q != 16'd0) begin
                            count_next = count_q - 16'd1;
                        end else begin
                            state_next = DONE;
                            int_next   = 1'b1;
                        end
                    end else begin
                        pre_next = pre_q + 16'd1;
                    end
                end
                DONE: begin
                    if (!start_vec[g]) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        assign int_vec[g]  = int_q;
        assign busy_vec[g] = (state_q == RUN);
    end

endmodule
